// File: rtl/sensor_frame_sched.sv
// rtl/sensor_frame_sched.sv - telemetry frame scheduler for the sensor register bank
// Walks FIRST_ADDR..LAST_ADDR and emits sync, seq, payload, checksum as a byte stream.
module sensor_frame_sched #(
  parameter logic [7:0]  FIRST_ADDR = 8'd1,
  parameter logic [7:0]  LAST_ADDR  = 8'd34,
  parameter int unsigned PERIOD     = 1000000,
  parameter logic [7:0]  SYNC       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_FETCH,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    acc;
  logic          tick;
  logic          trig;
  logic          hs;

  assign tick = enable && (cnt == CW'(PERIOD - 1));
  assign trig = tick | start;
  assign hs   = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= 8'd0;
      reg_addr   <= 8'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      seq        <= 8'd0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (!enable || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // A trigger that lands while a frame is in flight is dropped, only flagged.
      if (trig && state != S_IDLE) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (trig) begin
            state    <= S_SYNC;
            tx_data  <= SYNC;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SYNC: begin
          if (hs) begin
            state   <= S_SEQ;
            tx_data <= seq;
            acc     <= seq;
          end
        end
        S_SEQ: begin
          if (hs) begin
            state    <= S_FETCH;
            tx_valid <= 1'b0;
            reg_addr <= FIRST_ADDR;
          end
        end
        S_FETCH: begin
          // Bank read is combinational on reg_addr, so the byte is ready now.
          state    <= S_PAYLOAD;
          tx_data  <= reg_data;
          acc      <= acc + reg_data;
          tx_valid <= 1'b1;
        end
        S_PAYLOAD: begin
          if (hs) begin
            if (reg_addr == LAST_ADDR) begin
              state   <= S_CSUM;
              tx_data <= acc;
            end else begin
              state    <= S_FETCH;
              reg_addr <= reg_addr + 8'd1;
              tx_valid <= 1'b0;
            end
          end
        end
        S_CSUM: begin
          if (hs) begin
            state      <= S_IDLE;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            reg_addr   <= 8'd0;
            seq        <= seq + 8'd1;
            frame_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_frame_sched.sv
// tb/tb_sensor_frame_sched.sv - directed self-checking bench for sensor_frame_sched
module tb_sensor_frame_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic [7:0] seq;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [7:0] q[$];
  int sync_t[$];

  always #5 clk = ~clk;

  assign reg_data = reg_addr;

  sensor_frame_sched #(.PERIOD(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .seq         (seq),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
      if (tx_valid && tx_ready) begin
        q.push_back(tx_data);
        if (tx_data == 8'hA5) sync_t.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] s, input bit stall, input bit ovr);
    logic [7:0] b[37];
    logic [7:0] sum;
    bit hit;
    q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("sync_lat_valid", tx_valid, 1);
    chk("sync_lat_data", tx_data, 8'hA5);
    hit = 1'b0;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (stall && !hit && tx_valid && reg_addr == 8'd9) begin
        hit = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("stall_data", tx_data, 8'h0A);
          chk("stall_addr", reg_addr, 8'd10);
          chk("stall_valid", tx_valid, 1);
        end
        tx_ready = 1'b1;
      end
      if (ovr && c == 20) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("ovr_set", overrun, 1);
        @(posedge clk); #1 start = 1'b1; clr_overrun = 1'b1;
        @(posedge clk); #1 start = 1'b0; clr_overrun = 1'b0;
        chk("ovr_set_beats_clr", overrun, 1);
      end
    end
    chk("frame_timeout", (done_cnt > 0), 1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 37; i++) b[i] = (i < q.size()) ? q[i] : 8'hxx;
    sum = s;
    for (int i = 1; i <= 34; i++) sum = sum + 8'(i);
    chk("byte_count", q.size(), 37);
    chk("sync_byte", b[0], 8'hA5);
    chk("seq_byte", b[1], s);
    for (int i = 0; i < 34; i++) chk($sformatf("payload_%0d", i), b[2+i], 8'(i + 1));
    chk("csum_byte", b[36], sum);
    chk("busy_cycles", busy_cnt, stall ? 75 : 71);
    chk("done_pulses", done_cnt, 1);
    chk("seq_after", seq, s + 8'd1);
    chk("idle_busy", busy, 0);
    chk("idle_addr", reg_addr, 0);
    if (ovr) begin
      chk("ovr_sticky", overrun, 1);
      @(posedge clk); #1 clr_overrun = 1'b1;
      @(posedge clk); #1 clr_overrun = 1'b0;
      chk("ovr_clear", overrun, 0);
    end
  endtask

  initial begin
    bit found;
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_seq", seq, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;

    // Abandon a frame mid-payload with reset, then the restart reuses seq 0.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == 8'h10) found = 1'b1;
    end
    chk("reach_0x10", found, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_seq", seq, 0);
    rst = 1'b1;

    run_frame(8'd0, 1'b0, 1'b0);
    run_frame(8'd1, 1'b0, 1'b0);
    run_frame(8'd2, 1'b1, 1'b0);
    run_frame(8'd3, 1'b0, 1'b1);

    // Automatic triggers every 100 cycles, then disable.
    q.delete();
    sync_t.delete();
    @(posedge clk); #1 enable = 1'b1;
    c0 = cyc;
    repeat (350) @(negedge clk);
    @(posedge clk); #1 enable = 1'b0;
    repeat (250) @(negedge clk);
    chk("auto_bytes", q.size(), 111);
    chk("auto_syncs", sync_t.size(), 3);
    if (sync_t.size() == 3 && q.size() == 111) begin
      chk("auto_first", sync_t[0], c0 + 101);
      chk("auto_gap1", sync_t[1] - sync_t[0], 100);
      chk("auto_gap2", sync_t[2] - sync_t[1], 100);
      chk("auto_seq0", q[1], 8'd4);
      chk("auto_seq1", q[38], 8'd5);
      chk("auto_seq2", q[75], 8'd6);
    end
    chk("auto_seq_after", seq, 8'd7);
    chk("auto_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_frame_sched.md
Name: sensor_frame_sched

Overview:
- Telemetry frame scheduler for the sensor register bank.
- On a periodic tick or an external start, it walks the bank's byte addresses FIRST_ADDR..LAST_ADDR and captures each read byte.
- It emits one framed byte stream (sync, sequence, payload, checksum) over a valid/ready byte interface toward the radio/UART serializer.
- It is the only driver of the bank's address input.

Parameters:
FIRST_ADDR, 8'd1, first bank address read per frame (must be >=1; address 0 is the idle/unused address)
LAST_ADDR, 8'd34, last bank address read per frame (must be >= FIRST_ADDR)
PERIOD, 1000000, clk cycles between automatic frame triggers (must be > frame length in cycles; min 2)
SYNC, 8'hA5, frame sync byte

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
enable  in  1  1 = period counter runs; 0 = counter held at 0, no auto triggers
start  in  1  single-cycle manual frame request
reg_addr  out  8  address to sensor register bank
reg_data  in  8  byte from bank (combinational read of reg_addr)
tx_data  out  8  stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid & tx_ready at a rising edge
busy  out  1  1 from leaving IDLE until checksum accepted
frame_done  out  1  one-cycle pulse, the cycle after checksum handshake
seq  out  8  sequence number of the next/current frame
overrun  out  1  sticky: trigger arrived while busy
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (rst=0 at an edge). All outputs 0, state IDLE, period counter 0, checksum accumulator 0. Applies mid-frame too: tx_valid drops at that edge, the frame is abandoned, seq is not incremented.
- Period counter. Counts while enable=1. tick=1 when count==PERIOD-1; the counter then wraps to 0.
- Trigger. trig = tick | start.
  - In IDLE: the next state is SYNC.
  - In any other state: trig is dropped and overrun<=1.
  - overrun priority: set beats clr_overrun in the same cycle.
- enable=0 mid-frame: the frame completes normally.
- Registered outputs: tx_data, tx_valid, reg_addr, busy are all registered.
- States and transitions:
  - IDLE: reg_addr=0, tx_valid=0, busy=0.
  - SYNC: tx_data=SYNC, tx_valid=1. On handshake -> SEQ.
  - SEQ: tx_data=seq, tx_valid=1, acc<=seq. On handshake -> reg_addr<=FIRST_ADDR, go to FETCH.
  - FETCH (1 cycle, tx_valid=0): tx_data<=reg_data, acc<=acc+reg_data (mod 256) -> PAYLOAD.
  - PAYLOAD: tx_valid=1. On handshake:
    - if reg_addr==LAST_ADDR: tx_data<=acc, go to CSUM;
    - else reg_addr<=reg_addr+1, go to FETCH.
  - CSUM: tx_valid=1, tx_data=acc. On handshake: reg_addr<=0, seq<=seq+1 (wraps 8'hFF->8'h00), frame_done=1 the next cycle -> IDLE.
- Handshake/stall. While tx_valid=1 and tx_ready=0, tx_data and reg_addr are held stable. tx_ready is ignored when tx_valid=0.
- Checksum. 8-bit modular sum of the seq byte and all payload bytes; SYNC is excluded.
- Frame length. 3 + (LAST_ADDR-FIRST_ADDR+1) bytes.
- Timing with tx_ready held high:
  - SYNC valid one cycle after trig is sampled in IDLE.
  - Frame occupies 3 + 2*N cycles (N = payload bytes); default 71 cycles, 37 bytes.
  - Back-to-back triggers are accepted on the cycle after frame_done's source edge returns to IDLE.

Test Plan:
- Bank model reg_data=reg_addr, defaults, tx_ready=1, start pulse -> bytes A5,00,01..22(hex),53; busy high 71 cycles; frame_done one pulse; seq=1 after.
- Second start after frame_done -> A5,01,01..22,54; seq=2.
- tx_ready=0 for 5 cycles while tx_data=0x0A -> tx_data=0x0A, reg_addr=10, tx_valid=1 held all 5 cycles; stream resumes with no lost or duplicate byte.
- start pulsed mid-frame -> overrun=1, stream unchanged, no extra frame. clr_overrun and start together while busy -> overrun stays 1. clr_overrun alone -> overrun=0.
- PERIOD=100, enable=1, tx_ready=1 -> SYNC bytes every 100 cycles, seq increments 0,1,2; enable=0 -> no further frames.
- rst=0 during payload byte 0x10 -> next cycle all outputs 0, seq unchanged. Restart -> full frame with the same seq.
